// File: rtl/gain_ramp_stage.sv
// Streaming Q-format gain stage: two-stage multiply/saturate pipeline with a
// per-sample gain ramp. Define GAIN_CLIP_COUNT_EN to add the clip_count port.
module gain_ramp_stage #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32,
    parameter int ramp_step       = 16,
    parameter int reset_gain      = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [operand_size-1:0] in_sample,
    input  logic                    gain_load,
    input  logic [operand_size-1:0] gain_target,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [operand_size-1:0] out_sample,
    output logic                    out_clipped,
    output logic [operand_size-1:0] gain_current,
    output logic                    ramping
`ifdef GAIN_CLIP_COUNT_EN
    ,
    output logic [15:0]             clip_count
`endif
);

    localparam int W = operand_size;
    localparam logic signed [W-1:0]   GAIN_RST = W'(reset_gain);
    localparam logic signed [W:0]     STEP_X   = (W+1)'(ramp_step);
    localparam logic signed [W-1:0]   STEP_W   = W'(ramp_step);
    localparam logic signed [2*W-1:0] SAT_MAX  = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SAT_MIN  = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {HOLD, UP, DOWN} ramp_state_t;

    function automatic logic signed [2*W-1:0] fixed_multiply(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [2*W-1:0] ax;
        logic signed [2*W-1:0] bx;
        logic signed [2*W-1:0] full;
        ax   = {{W{a[W-1]}}, a};
        bx   = {{W{b[W-1]}}, b};
        full = ax * bx;
        return full >>> fractional_size;
    endfunction

    function automatic logic saturates(input logic signed [2*W-1:0] p);
        return (p > SAT_MAX) || (p < SAT_MIN);
    endfunction

    function automatic logic signed [W-1:0] saturate(input logic signed [2*W-1:0] p);
        if (p > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (p < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return p[W-1:0];
    endfunction

    ramp_state_t           state, state_next;
    logic signed [W-1:0]   gain_cur, gain_cur_next;
    logic signed [W-1:0]   gain_tgt, gain_tgt_next, tgt_eff;
    logic signed [W:0]     diff_up, diff_dn;
    logic signed [W-1:0]   delta;
    logic signed [W-1:0]   sample_s;
    logic signed [2*W-1:0] prod_p1;
    logic                  vld_p1;
    logic                  stage2_loads;
    logic                  accept;

    assign sample_s     = in_sample;
    assign stage2_loads = !out_valid || out_ready;
    assign in_ready     = !vld_p1 || stage2_loads;
    assign accept       = in_valid && in_ready;
    assign gain_current = gain_cur;
    assign ramping      = (state != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HOLD;
            gain_cur <= GAIN_RST;
            gain_tgt <= GAIN_RST;
        end else begin
            state    <= state_next;
            gain_cur <= gain_cur_next;
            gain_tgt <= gain_tgt_next;
        end
    end

    // A load in the same cycle as an accept steps toward the new target.
    always_comb begin
        tgt_eff       = gain_load ? $signed(gain_target) : gain_tgt;
        gain_tgt_next = tgt_eff;
        gain_cur_next = gain_cur;
        diff_up       = {tgt_eff[W-1], tgt_eff} - {gain_cur[W-1], gain_cur};
        diff_dn       = -diff_up;
        delta         = '0;
        if (accept) begin
            if (!diff_up[W] && (diff_up != '0)) begin
                delta         = (diff_up > STEP_X) ? STEP_W : diff_up[W-1:0];
                gain_cur_next = gain_cur + delta;
            end else if (diff_up[W]) begin
                delta         = (diff_dn > STEP_X) ? STEP_W : diff_dn[W-1:0];
                gain_cur_next = gain_cur - delta;
            end
        end
        state_next = HOLD;
        if (gain_cur_next < gain_tgt_next)
            state_next = UP;
        else if (gain_cur_next > gain_tgt_next)
            state_next = DOWN;
    end

    // Stage 1: double-width product; stage 2: saturated output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            prod_p1     <= '0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            out_clipped <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
                if (in_valid)
                    prod_p1 <= fixed_multiply(sample_s, gain_cur);
            end
            if (stage2_loads) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_sample  <= saturate(prod_p1);
                    out_clipped <= saturates(prod_p1);
                end
            end
        end
    end

`ifdef GAIN_CLIP_COUNT_EN
    logic [15:0] clip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_cnt <= '0;
        else if (out_valid && out_ready && out_clipped && (clip_cnt != 16'hFFFF))
            clip_cnt <= clip_cnt + 16'd1;
    end

    assign clip_count = clip_cnt;
`endif

endmodule
